rc4_phase_seq: RTL and testbench
================================

// Module: rc4_phase_seq
// PURPOSE
//  Parametrised sequencer for the RC4 cracking datapath: runs init -> ksa -> optional prga on one s_mem.
//  Host gets a start/rdy handshake and a latched key; each sub-block gets a one-cycle en pulse.
//  Owns the single s_mem port mux; adds per-phase timeout, abort, error status and a busy-cycle counter.
// PARAMETERS
//  ADDR_W       8      s_mem address width
//  DATA_W       8      s_mem data width
//  KEY_W        24     key width latched from key_in
//  TIMEOUT_CYC  65535  max cycles per phase in GO+RUN states; 0 disables timeout
//  TO_W         16     timeout counter width; must hold TIMEOUT_CYC
//  CNT_W        32     busy-cycle counter width
// PORTS
//  clk          in   1       single clock
//  rst_n        in   1       synchronous active-low reset
//  start        in   1       host start; accepted only while rdy=1
//  abort        in   1       synchronous abort to IDLE
//  mode_prga    in   1       sampled with start; 1 = run prga after ksa
//  key_in       in   KEY_W   key, latched on accepted start
//  rdy          out  1       high in IDLE, DONE, ERR
//  done         out  1       high in DONE only
//  err          out  1       high in ERR only
//  phase        out  2       0 idle/done/err, 1 init, 2 ksa, 3 prga
//  key_out      out  KEY_W   latched key, stable for the whole run
//  busy_cycles  out  CNT_W   cycles spent outside IDLE/DONE/ERR for the current run
//  {init,ksa,prga}_en     out 1   one-cycle start pulse to the sub-block
//  {init,ksa,prga}_rdy    in  1   sub-block ready; low while busy
//  {init,ksa,prga}_addr   in  ADDR_W ; _wrdata in DATA_W ; _wren in 1
//  mem_addr     out  ADDR_W  to s_mem
//  mem_wrdata   out  DATA_W  to s_mem
//  mem_wren     out  1       to s_mem
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state IDLE, done=err=0, rdy=1, phase=0, all en=0, key_out=0,
//   busy_cycles=0, mem_wren=0, mode latch=0, timer=0.
//  States: IDLE, INIT_GO, INIT_RUN, KSA_GO, KSA_RUN, PRGA_GO, PRGA_RUN, DONE, ERR.
//  IDLE/DONE/ERR + start & !abort -> INIT_GO; latch key_in, mode_prga; clear busy_cycles, timer.
//  X_GO: wait for X_rdy=1; on that cycle en=1 for exactly one cycle, go to X_RUN.
//  X_RUN: rdy sampled in the cycle after the en pulse is ignored (sub-block drop lag).
//   Afterwards X_rdy=1 -> next phase's GO, timer cleared.
//   After INIT -> KSA_GO; after KSA -> PRGA_GO if mode latch=1, else DONE; after PRGA -> DONE.
//  Timer increments every cycle in GO/RUN; reaching TIMEOUT_CYC -> ERR (en never issued there).
//  abort=1: any state -> IDLE next cycle, done/err cleared, no en pulse that cycle. abort beats start.
//  start outside IDLE/DONE/ERR is ignored; key_out does not change.
//  DONE/ERR hold until start or abort.
//  busy_cycles increments in GO/RUN states and saturates at all-ones (no wrap).
//  Mem mux (combinational from state): X_GO and X_RUN route X's addr/wrdata/wren.
//   All other states drive addr=0, wrdata=0, wren=0. No cycle has two owners.
//  en/done/err/phase/rdy are registered or decoded from registered state only; no combinational
//   path from any *_rdy to any en.
// STRUCTURE
//  rc4_pkg: seq_state_t enum; phase codes PH_IDLE/PH_INIT/PH_KSA/PH_PRGA.
//  Sub-module phase_timer: clear/enable inputs, TO_W count, expired flag; TIMEOUT_CYC=0 never expires.
//  Mux, FSM and counters stay in rc4_phase_seq.
// TESTING
//  Reset, then start with key_in=24'h00033C, mode_prga=0; sub models finish in 256 / 768 cycles
//   -> one init_en and one ksa_en pulse, no prga_en, done=1, key_out=24'h00033C.
//  Same run with mode_prga=1 and prga taking 100 cycles -> three en pulses in order, done=1,
//   busy_cycles within +/-8 of 1124.
//  TIMEOUT_CYC=300 with ksa_rdy held low -> err=1, phase=0, no done.
//   Then start -> clean rerun, err clears.
//  abort asserted mid-KSA -> IDLE next cycle, mem_wren=0, ksa_en never re-pulsed.
//   abort and start in the same cycle in IDLE -> stays IDLE.
//  Mux check: force distinct addr per sub-block -> mem_addr equals owner's addr in every GO/RUN
//   cycle, 0 elsewhere.
//  start pulsed during INIT_RUN with new key_in -> ignored, key_out unchanged.
//   CNT_W=4 -> busy_cycles saturates at 15.

Source files
------------

// File: rtl/rc4_phase_seq_pkg.sv
// Shared types and helpers for the RC4 phase sequencer.
package rc4_phase_seq_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StInitGo,
        StInitRun,
        StKsaGo,
        StKsaRun,
        StPrgaGo,
        StPrgaRun,
        StDone,
        StErr
    } seq_state_t;

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_INIT = 2'd1;
    localparam logic [1:0] PH_KSA  = 2'd2;
    localparam logic [1:0] PH_PRGA = 2'd3;

    function automatic logic [1:0] state_phase(input seq_state_t s);
        logic [1:0] ph;
        ph = PH_IDLE;
        case (s)
            StInitGo, StInitRun: ph = PH_INIT;
            StKsaGo, StKsaRun:   ph = PH_KSA;
            StPrgaGo, StPrgaRun: ph = PH_PRGA;
            default:             ph = PH_IDLE;
        endcase
        return ph;
    endfunction

    // GO/RUN states are the ones that burn timer and busy-cycle budget.
    function automatic logic state_active(input seq_state_t s);
        return s inside {StInitGo, StInitRun, StKsaGo, StKsaRun, StPrgaGo, StPrgaRun};
    endfunction

endpackage

// File: rtl/rc4_phase_seq_if.sv
// Host handshake, sub-block handshake and s_mem bus of the RC4 phase sequencer.
interface rc4_phase_seq_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned KEY_W  = 24,
    parameter int unsigned CNT_W  = 32
);
    logic              start;
    logic              abort;
    logic              mode_prga;
    logic [KEY_W-1:0]  key_in;
    logic              rdy;
    logic              done;
    logic              err;
    logic [1:0]        phase;
    logic [KEY_W-1:0]  key_out;
    logic [CNT_W-1:0]  busy_cycles;

    logic              init_en;
    logic              ksa_en;
    logic              prga_en;
    logic              init_rdy;
    logic              ksa_rdy;
    logic              prga_rdy;
    logic [ADDR_W-1:0] init_addr;
    logic [ADDR_W-1:0] ksa_addr;
    logic [ADDR_W-1:0] prga_addr;
    logic [DATA_W-1:0] init_wrdata;
    logic [DATA_W-1:0] ksa_wrdata;
    logic [DATA_W-1:0] prga_wrdata;
    logic              init_wren;
    logic              ksa_wren;
    logic              prga_wren;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wrdata;
    logic              mem_wren;

    modport slave (
        input  start, abort, mode_prga, key_in,
        input  init_rdy, ksa_rdy, prga_rdy,
        input  init_addr, ksa_addr, prga_addr,
        input  init_wrdata, ksa_wrdata, prga_wrdata,
        input  init_wren, ksa_wren, prga_wren,
        output rdy, done, err, phase, key_out, busy_cycles,
        output init_en, ksa_en, prga_en,
        output mem_addr, mem_wrdata, mem_wren
    );

    modport master (
        output start, abort, mode_prga, key_in,
        output init_rdy, ksa_rdy, prga_rdy,
        output init_addr, ksa_addr, prga_addr,
        output init_wrdata, ksa_wrdata, prga_wrdata,
        output init_wren, ksa_wren, prga_wren,
        input  rdy, done, err, phase, key_out, busy_cycles,
        input  init_en, ksa_en, prga_en,
        input  mem_addr, mem_wrdata, mem_wren
    );
endinterface

// File: rtl/rc4_phase_seq_phase_timer.sv
// Per-phase cycle timer; expires after TIMEOUT_CYC enabled cycles, never when TIMEOUT_CYC is 0.
module phase_timer #(
    parameter int unsigned TIMEOUT_CYC = 65535,
    parameter int unsigned TO_W        = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned LastCnt = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

    logic [TO_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + TO_W'(1);
        end
    end

    // count_q holds the number of cycles already spent, so the last allowed cycle expires.
    assign expired_o = en_i && (TIMEOUT_CYC != 0) && (count_q >= TO_W'(LastCnt));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/rc4_phase_seq.sv
// Sequencer running init -> ksa -> optional prga on one s_mem, with timeout, abort and
// busy-cycle accounting. Owns the s_mem port mux.
module rc4_phase_seq
    import rc4_phase_seq_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned KEY_W       = 24,
    parameter int unsigned TIMEOUT_CYC = 65535,
    parameter int unsigned TO_W        = 16,
    parameter int unsigned CNT_W       = 32
) (
    input logic            clk,
    input logic            rst_n,
    rc4_phase_seq_if.slave seq_if
);
    seq_state_t       state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] busy_q, busy_d;
    logic             init_en_q, init_en_d;
    logic             ksa_en_q, ksa_en_d;
    logic             prga_en_q, prga_en_d;
    logic             lag_q, lag_d;
    logic             tmr_clr;
    logic             tmr_exp;
    logic             active;
    logic             run_ok;

    assign active = state_active(state_q);
    // Sub-block rdy is stale during the en cycle and the one after it.
    assign run_ok = !(init_en_q || ksa_en_q || prga_en_q) && !lag_q;

    phase_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .TO_W       (TO_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (tmr_clr),
        .en_i     (active),
        .expired_o(tmr_exp)
    );

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        mode_d    = mode_q;
        busy_d    = busy_q;
        init_en_d = 1'b0;
        ksa_en_d  = 1'b0;
        prga_en_d = 1'b0;
        lag_d     = init_en_q || ksa_en_q || prga_en_q;
        tmr_clr   = 1'b0;

        if (active && (busy_q != '1)) begin
            busy_d = busy_q + CNT_W'(1);
        end

        if (seq_if.abort) begin
            state_d = StIdle;
        end else if (tmr_exp) begin
            state_d = StErr;
        end else begin
            unique case (state_q)
                StIdle, StDone, StErr: begin
                    if (seq_if.start) begin
                        state_d = StInitGo;
                        key_d   = seq_if.key_in;
                        mode_d  = seq_if.mode_prga;
                        busy_d  = '0;
                        tmr_clr = 1'b1;
                    end
                end
                StInitGo: begin
                    if (seq_if.init_rdy) begin
                        state_d   = StInitRun;
                        init_en_d = 1'b1;
                    end
                end
                StInitRun: begin
                    if (run_ok && seq_if.init_rdy) begin
                        state_d = StKsaGo;
                        tmr_clr = 1'b1;
                    end
                end
                StKsaGo: begin
                    if (seq_if.ksa_rdy) begin
                        state_d  = StKsaRun;
                        ksa_en_d = 1'b1;
                    end
                end
                StKsaRun: begin
                    if (run_ok && seq_if.ksa_rdy) begin
                        state_d = mode_q ? StPrgaGo : StDone;
                        tmr_clr = 1'b1;
                    end
                end
                StPrgaGo: begin
                    if (seq_if.prga_rdy) begin
                        state_d   = StPrgaRun;
                        prga_en_d = 1'b1;
                    end
                end
                StPrgaRun: begin
                    if (run_ok && seq_if.prga_rdy) begin
                        state_d = StDone;
                        tmr_clr = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            key_q     <= '0;
            mode_q    <= 1'b0;
            busy_q    <= '0;
            init_en_q <= 1'b0;
            ksa_en_q  <= 1'b0;
            prga_en_q <= 1'b0;
            lag_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            mode_q    <= mode_d;
            busy_q    <= busy_d;
            init_en_q <= init_en_d;
            ksa_en_q  <= ksa_en_d;
            prga_en_q <= prga_en_d;
            lag_q     <= lag_d;
        end
    end

    assign seq_if.rdy         = state_q inside {StIdle, StDone, StErr};
    assign seq_if.done        = (state_q == StDone);
    assign seq_if.err         = (state_q == StErr);
    assign seq_if.phase       = state_phase(state_q);
    assign seq_if.key_out     = key_q;
    assign seq_if.busy_cycles = busy_q;
    assign seq_if.init_en     = init_en_q;
    assign seq_if.ksa_en      = ksa_en_q;
    assign seq_if.prga_en     = prga_en_q;

    always_comb begin
        seq_if.mem_addr   = '0;
        seq_if.mem_wrdata = '0;
        seq_if.mem_wren   = 1'b0;
        case (state_q)
            StInitGo, StInitRun: begin
                seq_if.mem_addr   = seq_if.init_addr;
                seq_if.mem_wrdata = seq_if.init_wrdata;
                seq_if.mem_wren   = seq_if.init_wren;
            end
            StKsaGo, StKsaRun: begin
                seq_if.mem_addr   = seq_if.ksa_addr;
                seq_if.mem_wrdata = seq_if.ksa_wrdata;
                seq_if.mem_wren   = seq_if.ksa_wren;
            end
            StPrgaGo, StPrgaRun: begin
                seq_if.mem_addr   = seq_if.prga_addr;
                seq_if.mem_wrdata = seq_if.prga_wrdata;
                seq_if.mem_wren   = seq_if.prga_wren;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_rc4_phase_seq.sv
// Scoreboard bench: two sequencers (default, and TIMEOUT_CYC=300 / CNT_W=4) with sub-block models.
module tb_rc4_phase_seq;

    typedef struct {
        logic        done;
        logic        err;
        logic [23:0] key;
        int unsigned busy_lo;
        int unsigned busy_hi;
        int unsigned n_init;
        int unsigned n_ksa;
        int unsigned n_prga;
        logic [7:0]  order;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    int          cnt_a[3];
    int          cnt_b[3];
    int          len_a[3];
    int          len_b[3];
    logic        hold_b = 1'b0;
    int unsigned n_en[2][3];
    int unsigned tot_en[2][3];
    logic [7:0]  order_r[2];
    int unsigned mux_err[2];
    logic        rdy_prev[2];

    rc4_phase_seq_if #(.ADDR_W(8), .DATA_W(8), .KEY_W(24), .CNT_W(32)) if_a ();
    rc4_phase_seq_if #(.ADDR_W(8), .DATA_W(8), .KEY_W(24), .CNT_W(4)) if_b ();

    rc4_phase_seq #(
        .ADDR_W(8), .DATA_W(8), .KEY_W(24), .TIMEOUT_CYC(65535), .TO_W(16), .CNT_W(32)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .seq_if(if_a.slave)
    );

    rc4_phase_seq #(
        .ADDR_W(8), .DATA_W(8), .KEY_W(24), .TIMEOUT_CYC(300), .TO_W(16), .CNT_W(4)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .seq_if(if_b.slave)
    );

    // Sub-block models: after an en pulse, rdy stays low so the job spans len cycles.
    logic [2:0] en_a, en_b;
    assign en_a = {if_a.prga_en, if_a.ksa_en, if_a.init_en};
    assign en_b = {if_b.prga_en, if_b.ksa_en, if_b.init_en};

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) cnt_a[k] <= 0;
            else if (en_a[k]) cnt_a[k] <= len_a[k] - 1;
            else if (cnt_a[k] != 0) cnt_a[k] <= cnt_a[k] - 1;
            if (!rst_n) cnt_b[k] <= 0;
            else if (en_b[k]) cnt_b[k] <= len_b[k] - 1;
            else if (cnt_b[k] != 0) cnt_b[k] <= cnt_b[k] - 1;
        end
    end

    assign if_a.init_rdy = (cnt_a[0] == 0);
    assign if_a.ksa_rdy  = (cnt_a[1] == 0);
    assign if_a.prga_rdy = (cnt_a[2] == 0);
    assign if_b.init_rdy = (cnt_b[0] == 0);
    assign if_b.ksa_rdy  = (cnt_b[1] == 0) && !hold_b;
    assign if_b.prga_rdy = (cnt_b[2] == 0);

    assign if_a.init_addr = 8'h11;  assign if_a.init_wrdata = 8'hA1;  assign if_a.init_wren = 1'b1;
    assign if_a.ksa_addr  = 8'h22;  assign if_a.ksa_wrdata  = 8'hA2;  assign if_a.ksa_wren  = 1'b1;
    assign if_a.prga_addr = 8'h33;  assign if_a.prga_wrdata = 8'hA3;  assign if_a.prga_wren = 1'b1;
    assign if_b.init_addr = 8'h11;  assign if_b.init_wrdata = 8'hA1;  assign if_b.init_wren = 1'b1;
    assign if_b.ksa_addr  = 8'h22;  assign if_b.ksa_wrdata  = 8'hA2;  assign if_b.ksa_wren  = 1'b1;
    assign if_b.prga_addr = 8'h33;  assign if_b.prga_wrdata = 8'hA3;  assign if_b.prga_wren = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input logic [63:0] act,
                           input logic [63:0] lo, input logic [63:0] hi);
        n_checks++;
        if ((^act === 1'bx) || act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Scoreboard monitor: tallies en pulses and mux ownership, scores on each return to rdy.
    task automatic mon(input int d, input logic rdy, input logic done, input logic err,
                       input logic [1:0] ph, input logic [23:0] key, input logic [31:0] busy,
                       input logic [2:0] en, input logic [7:0] addr, input logic [7:0] wd,
                       input logic wren);
        logic [7:0] ea, ew;
        logic       ewr;
        exp_t       e;
        for (int k = 0; k < 3; k++) begin
            if (en[k] === 1'b1) begin
                n_en[d][k]++;
                tot_en[d][k]++;
                order_r[d] = {order_r[d][5:0], 2'(k + 1)};
            end
        end
        case (ph)
            2'd1:    begin ea = 8'h11; ew = 8'hA1; ewr = 1'b1; end
            2'd2:    begin ea = 8'h22; ew = 8'hA2; ewr = 1'b1; end
            2'd3:    begin ea = 8'h33; ew = 8'hA3; ewr = 1'b1; end
            default: begin ea = 8'h00; ew = 8'h00; ewr = 1'b0; end
        endcase
        if (addr !== ea || wd !== ew || wren !== ewr) mux_err[d]++;
        if (rdy === 1'b1 && rdy_prev[d] === 1'b0) begin
            if ((d == 0) ? (q_a.size() == 0) : (q_b.size() == 0)) begin
                n_checks++;
                n_err++;
                $display("FAIL d%0d_unexpected_completion: got rdy=1 expected none queued", d);
            end else begin
                e = (d == 0) ? q_a.pop_front() : q_b.pop_front();
                chk($sformatf("d%0d_done", d), 64'(done), 64'(e.done));
                chk($sformatf("d%0d_err", d), 64'(err), 64'(e.err));
                chk($sformatf("d%0d_phase", d), 64'(ph), 64'(0));
                chk($sformatf("d%0d_key_out", d), 64'(key), 64'(e.key));
                chk_rng($sformatf("d%0d_busy_cycles", d), 64'(busy), 64'(e.busy_lo),
                        64'(e.busy_hi));
                chk($sformatf("d%0d_n_init_en", d), 64'(n_en[d][0]), 64'(e.n_init));
                chk($sformatf("d%0d_n_ksa_en", d), 64'(n_en[d][1]), 64'(e.n_ksa));
                chk($sformatf("d%0d_n_prga_en", d), 64'(n_en[d][2]), 64'(e.n_prga));
                chk($sformatf("d%0d_en_order", d), 64'(order_r[d]), 64'(e.order));
                chk($sformatf("d%0d_mux_errs", d), 64'(mux_err[d]), 64'(0));
            end
            for (int k = 0; k < 3; k++) n_en[d][k] = 0;
            order_r[d] = '0;
            mux_err[d] = 0;
        end
        rdy_prev[d] = rdy;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, if_a.rdy, if_a.done, if_a.err, if_a.phase, if_a.key_out, if_a.busy_cycles,
                en_a, if_a.mem_addr, if_a.mem_wrdata, if_a.mem_wren);
            mon(1, if_b.rdy, if_b.done, if_b.err, if_b.phase, if_b.key_out,
                32'(if_b.busy_cycles), en_b, if_b.mem_addr, if_b.mem_wrdata, if_b.mem_wren);
        end
    end

    function automatic logic get_rdy(input int d);
        return (d == 0) ? if_a.rdy : if_b.rdy;
    endfunction

    function automatic logic [1:0] get_phase(input int d);
        return (d == 0) ? if_a.phase : if_b.phase;
    endfunction

    task automatic start_run(input int d, input logic [23:0] key, input logic mode);
        if (d == 0) begin
            if_a.key_in = key; if_a.mode_prga = mode; if_a.start = 1'b1;
            @(negedge clk);
            if_a.start = 1'b0;
        end else begin
            if_b.key_in = key; if_b.mode_prga = mode; if_b.start = 1'b1;
            @(negedge clk);
            if_b.start = 1'b0;
        end
    endtask

    task automatic wait_rdy(input int d, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (get_rdy(d) === 1'b1) break;
            @(negedge clk);
        end
        chk($sformatf("d%0d_rdy_within_budget", d), 64'(i < budget), 64'(1));
    endtask

    task automatic wait_phase(input int d, input logic [1:0] ph, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (get_phase(d) === ph) break;
            @(negedge clk);
        end
        chk($sformatf("d%0d_phase%0d_within_budget", d, ph), 64'(i < budget), 64'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned snap;
        if_a.start = 0; if_a.abort = 0; if_a.mode_prga = 0; if_a.key_in = '0;
        if_b.start = 0; if_b.abort = 0; if_b.mode_prga = 0; if_b.key_in = '0;
        len_a = '{256, 768, 100};
        len_b = '{20, 5, 5};
        for (int d = 0; d < 2; d++) begin
            rdy_prev[d] = 1'b1; order_r[d] = '0; mux_err[d] = 0;
            for (int k = 0; k < 3; k++) begin n_en[d][k] = 0; tot_en[d][k] = 0; end
        end

        repeat (3) @(negedge clk);
        chk("rst_rdy", 64'(if_a.rdy), 64'(1));
        chk("rst_done_err", 64'({if_a.done, if_a.err, if_b.done, if_b.err}), 64'(0));
        chk("rst_phase", 64'(if_a.phase), 64'(0));
        chk("rst_key_out", 64'(if_a.key_out), 64'(0));
        chk("rst_busy", 64'(if_a.busy_cycles), 64'(0));
        chk("rst_en", 64'({en_a, en_b}), 64'(0));
        chk("rst_mem", 64'({if_a.mem_wren, if_a.mem_addr, if_b.mem_wren}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Run 1: no prga, 256 + 768 cycle sub-blocks; a stray start mid-init must be ignored.
        q_a.push_back('{1'b1, 1'b0, 24'h00033C, 1028, 1028, 1, 1, 0, 8'h06});
        start_run(0, 24'h00033C, 1'b0);
        wait_phase(0, 2'd1, 10);
        repeat (10) @(negedge clk);
        start_run(0, 24'hFFFFFF, 1'b1);
        chk("ignored_start_key_out", 64'(if_a.key_out), 64'(24'h00033C));
        chk("ignored_start_phase", 64'(if_a.phase), 64'(1));
        wait_rdy(0, 3000);
        @(negedge clk);

        // Run 2: with prga.
        q_a.push_back('{1'b1, 1'b0, 24'h00033C, 1116, 1132, 1, 1, 1, 8'h1B});
        start_run(0, 24'h00033C, 1'b1);
        wait_rdy(0, 3000);
        @(negedge clk);

        // Run 3: abort mid-KSA.
        q_a.push_back('{1'b0, 1'b0, 24'h0000AA, 258, 1100, 1, 1, 0, 8'h06});
        start_run(0, 24'h0000AA, 1'b0);
        wait_phase(0, 2'd2, 600);
        repeat (50) @(negedge clk);
        if_a.abort = 1'b1;
        @(negedge clk);
        if_a.abort = 1'b0;
        chk("abort_phase", 64'(if_a.phase), 64'(0));
        chk("abort_rdy_done", 64'({if_a.rdy, if_a.done}), 64'(2'b10));
        chk("abort_mem_wren", 64'(if_a.mem_wren), 64'(0));
        snap = tot_en[0][1];
        repeat (20) @(negedge clk);
        chk("abort_no_ksa_repulse", 64'(tot_en[0][1]), 64'(snap));

        // abort beats start in IDLE.
        snap = tot_en[0][0];
        if_a.key_in = 24'h555555; if_a.start = 1'b1; if_a.abort = 1'b1;
        @(negedge clk);
        if_a.start = 1'b0; if_a.abort = 1'b0;
        chk("abort_start_phase", 64'(if_a.phase), 64'(0));
        chk("abort_start_rdy", 64'(if_a.rdy), 64'(1));
        chk("abort_start_key", 64'(if_a.key_out), 64'(24'h0000AA));
        repeat (5) @(negedge clk);
        chk("abort_start_no_init_en", 64'(tot_en[0][0]), 64'(snap));

        // Timeout on KSA_GO (dut_b), busy saturates at 15; then a clean rerun.
        hold_b = 1'b1;
        q_b.push_back('{1'b0, 1'b1, 24'hABCDEF, 15, 15, 1, 0, 0, 8'h01});
        start_run(1, 24'hABCDEF, 1'b0);
        wait_rdy(1, 1000);
        chk("timeout_err", 64'(if_b.err), 64'(1));
        chk("timeout_done", 64'(if_b.done), 64'(0));
        chk("timeout_phase", 64'(if_b.phase), 64'(0));
        @(negedge clk);
        hold_b = 1'b0;
        len_b = '{5, 5, 5};
        q_b.push_back('{1'b1, 1'b0, 24'h123456, 14, 14, 1, 1, 0, 8'h06});
        start_run(1, 24'h123456, 1'b0);
        chk("rerun_err_cleared", 64'(if_b.err), 64'(0));
        wait_rdy(1, 200);
        chk("rerun_done", 64'(if_b.done), 64'(1));

        repeat (3) @(negedge clk);
        chk("pending_a", 64'(q_a.size()), 64'(0));
        chk("pending_b", 64'(q_b.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
